rcb_arb: RTL and testbench

RAM control block sitting directly downstream of the host programming block on one hpb_if (symbol, price, volume or order RCB instance). It arbitrates a single-port RAM between latency-critical lookup reads from the strategy datapath and host configuration writes. Writes carry byte enables. Lookup responses come back after a fixed pipeline latency. rcb_wr_done tells the upstream block that the write has committed.

---
 rtl/tts_pkg.sv | 23 ++
 rtl/rcb_rd_pipe.sv | 41 ++++
 rtl/rcb_arb.sv | 114 +++++++++++
 tb/tb_rcb_arb.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tts_pkg.sv
// Shared types and constants for the RAM control block slice.
package tts_pkg;

  localparam int unsigned RCB_DATA_WIDTH     = 64;
  localparam int unsigned RCB_ADDR_WIDTH     = 10;
  localparam int unsigned RCB_RD_LATENCY_MAX = 4;

  typedef enum logic [1:0] {
    IDLE,
    WR_PEND,
    WR_DONE,
    WR_REL
  } t_rcb_wr_state;

  typedef struct packed {
    logic                          en;
    logic                          we;
    logic [RCB_ADDR_WIDTH-1:0]     addr;
    logic [RCB_DATA_WIDTH-1:0]     wdata;
    logic [RCB_DATA_WIDTH/8-1:0]   be;
  } t_rcb_ram_req;

endpackage

// File: rtl/rcb_rd_pipe.sv
// Lookup response delay line: tracks issued reads across the RAM latency
// and registers the returning word together with its valid flag.
module rcb_rd_pipe
  import tts_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RCB_DATA_WIDTH,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd_issue,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  lk_rsp_valid,
  output logic [DATA_WIDTH-1:0] lk_rsp_data
);

  if (RD_LATENCY < 1 || RD_LATENCY > RCB_RD_LATENCY_MAX) begin : g_bad_latency
    $error("rcb_rd_pipe: RD_LATENCY out of range");
  end

  logic [RD_LATENCY-1:0] vld_sr;

  // Shift read-issue markers; capture RAM data when the oldest marker lands.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_sr       <= '0;
      lk_rsp_valid <= 1'b0;
      lk_rsp_data  <= '0;
    end else begin
      vld_sr[0] <= rd_issue;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
      lk_rsp_valid <= vld_sr[RD_LATENCY-1];
      if (vld_sr[RD_LATENCY-1]) begin
        lk_rsp_data <= ram_rdata;
      end
    end
  end

endmodule

// File: rtl/rcb_arb.sv
// RAM control block: arbitrates one single-port RAM between lookup reads
// (default winner) and host writes, with a starvation bound on writes.
module rcb_arb
  import tts_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = RCB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH      = RCB_ADDR_WIDTH,
  parameter int unsigned RD_LATENCY      = 2,
  parameter int unsigned WR_STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    hpb_wr_req,
  input  logic [ADDR_WIDTH-1:0]   hpb_wr_addr,
  input  logic [DATA_WIDTH-1:0]   hpb_wr_data,
  input  logic [DATA_WIDTH/8-1:0] hpb_wr_byte_en,
  output logic                    rcb_wr_done,
  input  logic                    lk_req_valid,
  input  logic [ADDR_WIDTH-1:0]   lk_req_addr,
  output logic                    lk_req_ready,
  output logic                    lk_rsp_valid,
  output logic [DATA_WIDTH-1:0]   lk_rsp_data,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  output logic [DATA_WIDTH/8-1:0] ram_be,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  localparam int unsigned CNT_W = $clog2(WR_STARVE_LIMIT + 1);

  t_rcb_wr_state    state;
  logic [CNT_W-1:0] starve_cnt;
  t_rcb_ram_req     ram_q;
  logic             wr_grant;
  logic             rd_grant;

  // Per-cycle grant: a pending write goes only when reads are absent or starved it.
  always_comb begin
    wr_grant     = (state == WR_PEND) &&
                   (!lk_req_valid || (starve_cnt == CNT_W'(WR_STARVE_LIMIT)));
    lk_req_ready = reset_n && !wr_grant;
    rd_grant     = lk_req_valid && lk_req_ready;
  end

  // Write handshake FSM; done is registered so it lands the cycle after issue.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      rcb_wr_done <= 1'b0;
    end else begin
      rcb_wr_done <= (state == WR_DONE);
      case (state)
        IDLE:    if (hpb_wr_req) state <= WR_PEND;
        WR_PEND: if (wr_grant) state <= WR_DONE;
        WR_DONE: state <= WR_REL;
        WR_REL:  if (!hpb_wr_req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Count reads that overtake a pending write; saturates at the limit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (wr_grant) begin
      starve_cnt <= '0;
    end else if ((state == WR_PEND) && rd_grant &&
                 (starve_cnt != CNT_W'(WR_STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Registered RAM port; address/data/byte enables hold on idle cycles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ram_q <= '0;
    end else begin
      ram_q.en <= 1'b0;
      ram_q.we <= 1'b0;
      if (wr_grant) begin
        ram_q.en    <= 1'b1;
        ram_q.we    <= 1'b1;
        ram_q.addr  <= hpb_wr_addr;
        ram_q.wdata <= hpb_wr_data;
        ram_q.be    <= hpb_wr_byte_en;
      end else if (rd_grant) begin
        ram_q.en   <= 1'b1;
        ram_q.addr <= lk_req_addr;
      end
    end
  end

  assign ram_en    = ram_q.en;
  assign ram_we    = ram_q.we;
  assign ram_addr  = ram_q.addr;
  assign ram_wdata = ram_q.wdata;
  assign ram_be    = ram_q.be;

  rcb_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk          (clk),
    .reset_n      (reset_n),
    .rd_issue     (ram_q.en & ~ram_q.we),
    .ram_rdata    (ram_rdata),
    .lk_rsp_valid (lk_rsp_valid),
    .lk_rsp_data  (lk_rsp_data)
  );

endmodule

// File: tb/tb_rcb_arb.sv
// Directed bench for rcb_arb with a behavioural byte-enabled RAM of latency 2.
module tb_rcb_arb;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          hpb_wr_req;
  logic [AW-1:0] hpb_wr_addr;
  logic [DW-1:0] hpb_wr_data;
  logic [7:0]    hpb_wr_byte_en;
  logic          rcb_wr_done;
  logic          lk_req_valid;
  logic [AW-1:0] lk_req_addr;
  logic          lk_req_ready;
  logic          lk_rsp_valid;
  logic [DW-1:0] lk_rsp_data;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [7:0]    ram_be;
  logic [DW-1:0] ram_rdata;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  rcb_arb #(
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .RD_LATENCY      (2),
    .WR_STARVE_LIMIT (8)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .hpb_wr_req     (hpb_wr_req),
    .hpb_wr_addr    (hpb_wr_addr),
    .hpb_wr_data    (hpb_wr_data),
    .hpb_wr_byte_en (hpb_wr_byte_en),
    .rcb_wr_done    (rcb_wr_done),
    .lk_req_valid   (lk_req_valid),
    .lk_req_addr    (lk_req_addr),
    .lk_req_ready   (lk_req_ready),
    .lk_rsp_valid   (lk_rsp_valid),
    .lk_rsp_data    (lk_rsp_data),
    .ram_en         (ram_en),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_be         (ram_be),
    .ram_rdata      (ram_rdata)
  );

  // RAM model: single port, byte-enabled writes, two-cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_s0, rd_s1;
  assign ram_rdata = rd_s1;

  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      for (int b = 0; b < 8; b++)
        if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
    if (ram_en && !ram_we) rd_s0 <= mem[ram_addr];
    rd_s1 <= rd_s0;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [7:0] be);
    logic got;
    hpb_wr_req = 1'b1; hpb_wr_addr = a; hpb_wr_data = d; hpb_wr_byte_en = be;
    got = 1'b0;
    for (int c = 0; c < 16 && !got; c++) begin
      @(negedge clk);
      if (ram_we === 1'b1) got = 1'b1;
    end
    chk("wr_issue", {63'd0, got}, 64'd1);
    if (got) begin
      chk("wr_addr", {54'd0, ram_addr}, {54'd0, a});
      chk("wr_be", {56'd0, ram_be}, {56'd0, be});
      @(negedge clk);
      chk("wr_done", {63'd0, rcb_wr_done}, 64'd1);
    end
    hpb_wr_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    lk_req_valid = 1'b1; lk_req_addr = a;
    @(negedge clk);
    lk_req_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early1"}, {63'd0, lk_rsp_valid}, 64'd0);
    @(negedge clk);
    chk({tag, "_early2"}, {63'd0, lk_rsp_valid}, 64'd0);
    @(negedge clk);
    chk({tag, "_valid"}, {63'd0, lk_rsp_valid}, 64'd1);
    chk({tag, "_data"}, lk_rsp_data, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] exp_d;
    reset_n = 1'b0; hpb_wr_req = 1'b0; hpb_wr_addr = '0; hpb_wr_data = '0;
    hpb_wr_byte_en = '0; lk_req_valid = 1'b0; lk_req_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {63'd0, lk_req_ready}, 64'd0);
    chk("rst_ram_en", {63'd0, ram_en}, 64'd0);
    chk("rst_rsp_valid", {63'd0, lk_rsp_valid}, 64'd0);
    chk("rst_done", {63'd0, rcb_wr_done}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, lk_req_ready}, 64'd1);

    // Idle write with request held for three extra cycles.
    hpb_wr_req = 1'b1; hpb_wr_addr = 10'h005;
    hpb_wr_data = 64'h1122334455667788; hpb_wr_byte_en = 8'hFF;
    @(negedge clk);
    chk("w1_pend_we", {63'd0, ram_we}, 64'd0);
    chk("w1_pend_ready", {63'd0, lk_req_ready}, 64'd0);
    @(negedge clk);
    chk("w1_we", {63'd0, ram_we}, 64'd1);
    chk("w1_addr", {54'd0, ram_addr}, 64'h5);
    chk("w1_wdata", ram_wdata, 64'h1122334455667788);
    chk("w1_done_early", {63'd0, rcb_wr_done}, 64'd0);
    @(negedge clk);
    chk("w1_done", {63'd0, rcb_wr_done}, 64'd1);
    chk("w1_en_after", {63'd0, ram_en}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("w1_hold_done", {63'd0, rcb_wr_done}, 64'd0);
      chk("w1_hold_en", {63'd0, ram_en}, 64'd0);
    end
    hpb_wr_req = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Byte-enable merge.
    do_write(10'h010, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    do_write(10'h010, 64'h0, 8'h0F);
    do_read("be_merge", 10'h010, 64'hFFFFFFFF00000000);

    // Zero byte enables: write still completes, memory unchanged.
    do_write(10'h040, 64'h0123456789ABCDEF, 8'hFF);
    do_write(10'h040, 64'hDEADBEEFDEADBEEF, 8'h00);
    do_read("be_zero", 10'h040, 64'h0123456789ABCDEF);

    // Back-to-back reads of addresses 0..3.
    for (int i = 0; i < 4; i++) do_write(AW'(i), 64'hC0DE000000000000 | 64'(i), 8'hFF);
    lk_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lk_req_addr = AW'(i);
      chk("b2b_ready", {63'd0, lk_req_ready}, 64'd1);
      @(negedge clk);
      if (i < 3) chk("b2b_early", {63'd0, lk_rsp_valid}, 64'd0);
    end
    lk_req_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      exp_d = 64'hC0DE000000000000 | 64'(j);
      chk("b2b_valid", {63'd0, lk_rsp_valid}, 64'd1);
      chk("b2b_data", lk_rsp_data, exp_d);
      @(negedge clk);
    end
    chk("b2b_tail", {63'd0, lk_rsp_valid}, 64'd0);

    // Starvation bound: continuous reads with a write pending.
    lk_req_valid = 1'b1; lk_req_addr = 10'h007;
    hpb_wr_req = 1'b1; hpb_wr_addr = 10'h030; hpb_wr_data = 64'h5A5A; hpb_wr_byte_en = 8'hFF;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk("starve_rd_grant", {63'd0, lk_req_ready}, 64'd1);
      @(negedge clk);
    end
    chk("starve_forced", {63'd0, lk_req_ready}, 64'd0);
    @(negedge clk);
    chk("starve_we", {63'd0, ram_we}, 64'd1);
    chk("starve_addr", {54'd0, ram_addr}, 64'h30);
    chk("starve_resume", {63'd0, lk_req_ready}, 64'd1);
    hpb_wr_req = 1'b0;
    lk_req_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Write in cycle N, read issued in cycle N+1.
    hpb_wr_req = 1'b1; hpb_wr_addr = 10'h020; hpb_wr_data = 64'hABCD; hpb_wr_byte_en = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    chk("wr_rd_we", {63'd0, ram_we}, 64'd1);
    hpb_wr_req = 1'b0;
    lk_req_valid = 1'b1; lk_req_addr = 10'h020;
    @(negedge clk);
    lk_req_valid = 1'b0;
    chk("wr_rd_issue", {62'd0, ram_en, ram_we}, 64'h2);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("wr_rd_valid", {63'd0, lk_rsp_valid}, 64'd1);
    chk("wr_rd_data", lk_rsp_data, 64'hABCD);
    repeat (3) @(negedge clk);

    // Reset with two reads in flight and a write pending.
    lk_req_valid = 1'b1; lk_req_addr = 10'h000;
    hpb_wr_req = 1'b1; hpb_wr_addr = 10'h050; hpb_wr_data = 64'h77; hpb_wr_byte_en = 8'hFF;
    @(negedge clk);
    lk_req_addr = 10'h001;
    @(negedge clk);
    lk_req_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", {63'd0, lk_req_ready}, 64'd0);
    chk("mid_rst_en", {63'd0, ram_en}, 64'd0);
    reset_n = 1'b1;
    hpb_wr_req = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready_after", {63'd0, lk_req_ready}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      chk("mid_rst_no_rsp", {63'd0, lk_rsp_valid}, 64'd0);
      chk("mid_rst_no_done", {63'd0, rcb_wr_done}, 64'd0);
      chk("mid_rst_no_ram", {63'd0, ram_en}, 64'd0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
